// File: rtl/aes_trace_sequencer.sv
// Trace sequencer: launches one AES run per host command, arms capture,
// then streams a sync byte plus PT/key/CT/sample frame out over UART.
module aes_trace_sequencer #(
  parameter int NSAMP    = 512,
  parameter int TIMEOUT  = 1024,
  parameter int COOLDOWN = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  input  logic [7:0] cmd_byte,
  input  logic       aes_done,
  input  logic [7:0] mem_rdata,
  input  logic       tx_done,
  output logic       aes_start,
  output logic       cap_arm,
  output logic [9:0] mem_raddr,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic [4:0] delay_cfg,
  output logic       timeout_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] SYNC      = 3'd3;
  localparam logic [2:0] RD        = 3'd4;
  localparam logic [2:0] LOAD      = 3'd5;
  localparam logic [2:0] WAIT_TX   = 3'd6;
  localparam logic [2:0] COOL      = 3'd7;

  localparam int CMAX = (TIMEOUT > COOLDOWN) ? TIMEOUT : COOLDOWN;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COOLDOWN - 1);
  localparam logic [9:0]    I_LAST = 10'(47 + NSAMP);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [9:0]    idx;
  logic          hdr;
  logic          cmd_inc;
  logic          cmd_ld;

  assign cmd_inc = cmd_vld && (cmd_byte == 8'hFA);
  assign cmd_ld  = cmd_vld && (cmd_byte[7:5] == 3'b000);

  // cnt is zero during START, so WAIT_DONE sees cnt == cycles since aes_start
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      hdr         <= 1'b0;
      aes_start   <= 1'b0;
      cap_arm     <= 1'b0;
      mem_raddr   <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      delay_cfg   <= '0;
      timeout_err <= 1'b0;
    end else begin
      aes_start <= 1'b0;
      tx_start  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_inc || cmd_ld) begin
            delay_cfg   <= cmd_inc ? delay_cfg + 5'd1
                                   : cmd_byte[4:0];
            timeout_err <= 1'b0;
            aes_start   <= 1'b1;
            cap_arm     <= 1'b1;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          cnt   <= cnt + CW'(1);
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + CW'(1);
          if (aes_done) begin
            cap_arm  <= 1'b0;
            tx_byte  <= 8'hA5;
            tx_start <= 1'b1;
            state    <= SYNC;
          end else if (cnt == T_LAST) begin
            cap_arm     <= 1'b0;
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= COOL;
          end
        end
        SYNC: begin
          idx       <= '0;
          mem_raddr <= '0;
          hdr       <= 1'b1;
          state     <= WAIT_TX;
        end
        RD: begin
          mem_raddr <= idx;
          state     <= LOAD;
        end
        LOAD: begin
          tx_byte  <= mem_rdata;
          tx_start <= 1'b1;
          state    <= WAIT_TX;
        end
        WAIT_TX: begin
          // address leads into RD so the synchronous read lands in LOAD
          if (tx_done) begin
            if (hdr) begin
              hdr   <= 1'b0;
              state <= RD;
            end else if (idx == I_LAST) begin
              cnt   <= '0;
              state <= COOL;
            end else begin
              idx       <= idx + 10'd1;
              mem_raddr <= idx + 10'd1;
              state     <= RD;
            end
          end
        end
        COOL: begin
          if (cnt == C_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Directed bench for aes_trace_sequencer: UART responder, sync memory
// model and frame capture queue, one task per scenario.
module tb_aes_trace_sequencer;

  localparam int NSAMP    = 512;
  localparam int TIMEOUT  = 1024;
  localparam int COOLDOWN = 4096;
  localparam int FLEN     = 49 + NSAMP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_vld = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       aes_done = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       tx_done = 1'b0;
  logic       aes_start;
  logic       cap_arm;
  logic [9:0] mem_raddr;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       busy;
  logic [4:0] delay_cfg;
  logic       timeout_err;

  aes_trace_sequencer #(
    .NSAMP(NSAMP), .TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_byte(cmd_byte),
    .aes_done(aes_done), .mem_rdata(mem_rdata), .tx_done(tx_done),
    .aes_start(aes_start), .cap_arm(cap_arm), .mem_raddr(mem_raddr),
    .tx_start(tx_start), .tx_byte(tx_byte), .busy(busy),
    .delay_cfg(delay_cfg), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = 8'((i * 7) ^ (i >> 2) ^ 92);
  end
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  logic [7:0] frame_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  // UART TX model: tx_done two cycles after tx_start; optional 2-cycle pulse
  bit pend = 0, hold2 = 0, spur_req = 0, spur_mode = 0;
  int pcnt = 0, dbl_start = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_done = hold2 | spur_req;
      hold2 = 0;
      spur_req = 0;
      if (pend) begin
        if (pcnt == 0) begin
          tx_done = 1'b1; pend = 0; hold2 = spur_mode;
        end else pcnt--;
      end
      if (tx_start) begin
        frame_q.push_back(tx_byte);
        if (pend) dbl_start++;
        pend = 1; pcnt = 1;
      end
    end
  end

  function automatic int frame_err();
    if (frame_q.size() != FLEN) return -2;
    if (frame_q[0] != 8'hA5) return 0;
    for (int i = 1; i < FLEN; i++)
      if (frame_q[i] != mem[i-1]) return i;
    return -1;
  endfunction

  int r_starts, r_caps, r_terr_cyc, r_idle_cyc;
  logic r_start0, r_busy0, r_terr0;
  logic [4:0] r_delay0;
  bit r_hang;

  task automatic run_frame(input logic [7:0] c, input int lat,
                           input int abort_cyc, input bit inj);
    frame_q.delete();
    r_starts = 0; r_caps = 0; r_terr_cyc = -1; r_idle_cyc = -1;
    r_hang = 1;
    @(posedge clk); #1;
    cmd_vld = 1'b1; cmd_byte = c;
    @(posedge clk); #1;
    cmd_vld = 1'b0; cmd_byte = 8'h00;
    r_start0 = aes_start; r_busy0 = busy;
    r_terr0 = timeout_err; r_delay0 = delay_cfg;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (aes_start) r_starts++;
      if (cap_arm) r_caps++;
      if (timeout_err && r_terr_cyc < 0) r_terr_cyc = cyc;
      if (!busy) begin
        r_idle_cyc = cyc; r_hang = 0; break;
      end
      if (cyc == abort_cyc) begin
        rst = 1'b1; r_hang = 0; break;
      end
      aes_done = (cyc == lat - 1);
      if (inj && (cyc == 200 || cyc == 1500 || cyc == 4100)) begin
        cmd_vld = 1'b1;
        cmd_byte = (cyc == 4100) ? 8'h03 : 8'hFA;
      end else begin
        cmd_vld = 1'b0;
      end
      if (inj && (cyc == 2 || cyc == 4000)) spur_req = 1;
      @(posedge clk); #1;
    end
    aes_done = 1'b0;
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_vld = 1'b1; cmd_byte = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({aes_start, cap_arm, tx_start, busy, timeout_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 00000",
               {aes_start, cap_arm, tx_start, busy, timeout_err});
    end
    n_tests++;
    if (mem_raddr !== 10'd0) begin
      n_fail++; $display("FAIL rst_raddr: got %0d want 0", mem_raddr);
    end
    n_tests++;
    if (tx_byte !== 8'd0) begin
      n_fail++; $display("FAIL rst_txbyte: got %0h want 0", tx_byte);
    end
    n_tests++;
    if (delay_cfg !== 5'd0) begin
      n_fail++; $display("FAIL rst_delay: got %0d want 0", delay_cfg);
    end
    cmd_vld = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_frame();
    int e;
    run_frame(8'h07, 20, -1, 0);
    e = frame_err();
    n_tests++;
    if (r_delay0 !== 5'd7) begin
      n_fail++; $display("FAIL frame_delay: got %0d want 7", r_delay0);
    end
    n_tests++;
    if (r_start0 !== 1'b1 || r_busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start0: got %b%b want 11", r_start0, r_busy0);
    end
    n_tests++;
    if (r_starts !== 1) begin
      n_fail++; $display("FAIL frame_aes_pulses: got %0d want 1", r_starts);
    end
    n_tests++;
    if (r_caps !== 20) begin
      n_fail++; $display("FAIL frame_cap_cycles: got %0d want 20", r_caps);
    end
    n_tests++;
    if (r_hang !== 1'b0 || frame_q.size() !== FLEN) begin
      n_fail++;
      $display("FAIL frame_len: got %0d want %0d (hang=%0d)",
               frame_q.size(), FLEN, r_hang);
    end
    n_tests++;
    if (e !== -1) begin
      n_fail++; $display("FAIL frame_content: bad byte %0d want none", e);
    end
    n_tests++;
    if (r_idle_cyc !== 20 + 5 * (FLEN - 1) + 3 + COOLDOWN) begin
      n_fail++;
      $display("FAIL frame_idle_cyc: got %0d want %0d", r_idle_cyc,
               20 + 5 * (FLEN - 1) + 3 + COOLDOWN);
    end
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL frame_terr: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_timeout();
    run_frame(8'h1F, 0, -1, 0);
    n_tests++;
    if (r_delay0 !== 5'd31) begin
      n_fail++; $display("FAIL to_delay: got %0d want 31", r_delay0);
    end
    n_tests++;
    if (r_terr_cyc !== TIMEOUT) begin
      n_fail++;
      $display("FAIL to_terr_cyc: got %0d want %0d", r_terr_cyc, TIMEOUT);
    end
    n_tests++;
    if (frame_q.size() !== 0) begin
      n_fail++; $display("FAIL to_no_tx: got %0d want 0", frame_q.size());
    end
    n_tests++;
    if (r_idle_cyc !== TIMEOUT + COOLDOWN) begin
      n_fail++;
      $display("FAIL to_idle_cyc: got %0d want %0d",
               r_idle_cyc, TIMEOUT + COOLDOWN);
    end
    n_tests++;
    if (r_caps !== TIMEOUT) begin
      n_fail++;
      $display("FAIL to_cap_cycles: got %0d want %0d", r_caps, TIMEOUT);
    end
    n_tests++;
    if (timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_sticky: got %b want 1", timeout_err);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] bad [2];
    bad[0] = 8'h40;
    bad[1] = 8'h20;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      cmd_vld = 1'b1; cmd_byte = bad[k];
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || aes_start !== 1'b0) begin
        n_fail++;
        $display("FAIL ign_%0h: got busy=%b start=%b want 0 0",
                 bad[k], busy, aes_start);
      end
    end
    n_tests++;
    if (delay_cfg !== 5'd31 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_state: got delay=%0d terr=%b want 31 1",
               delay_cfg, timeout_err);
    end
  endtask

  task automatic test_wrap_terminal();
    int e;
    run_frame(8'hFA, TIMEOUT, -1, 0);
    e = frame_err();
    n_tests++;
    if (r_delay0 !== 5'd0 || r_start0 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_delay: got %0d start=%b want 0 1",
               r_delay0, r_start0);
    end
    n_tests++;
    if (r_terr0 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_terr_clear: got %b want 0", r_terr0);
    end
    n_tests++;
    if (r_terr_cyc !== -1) begin
      n_fail++; $display("FAIL term_terr: got cyc %0d want never", r_terr_cyc);
    end
    n_tests++;
    if (e !== -1) begin
      n_fail++; $display("FAIL term_frame: bad byte %0d want none", e);
    end
    n_tests++;
    if (r_idle_cyc !== TIMEOUT + 5 * (FLEN - 1) + 3 + COOLDOWN) begin
      n_fail++;
      $display("FAIL term_idle_cyc: got %0d want %0d", r_idle_cyc,
               TIMEOUT + 5 * (FLEN - 1) + 3 + COOLDOWN);
    end
  endtask

  task automatic test_spurious();
    int e;
    spur_mode = 1;
    run_frame(8'h0A, 5, -1, 1);
    spur_mode = 0;
    e = frame_err();
    n_tests++;
    if (e !== -1) begin
      n_fail++; $display("FAIL spur_frame: bad byte %0d want none", e);
    end
    n_tests++;
    if (r_idle_cyc !== 5 + 5 * (FLEN - 1) + 3 + COOLDOWN) begin
      n_fail++;
      $display("FAIL spur_idle_cyc: got %0d want %0d", r_idle_cyc,
               5 + 5 * (FLEN - 1) + 3 + COOLDOWN);
    end
    n_tests++;
    if (delay_cfg !== 5'd10 || r_starts !== 1) begin
      n_fail++;
      $display("FAIL spur_cmd: got delay=%0d starts=%0d want 10 1",
               delay_cfg, r_starts);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    run_frame(8'h0C, 3, 1000, 0);
    n_tests++;
    if (frame_q.size() <= 49) begin
      n_fail++;
      $display("FAIL mid_progress: got %0d bytes want >49", frame_q.size());
    end
    @(posedge clk); #1;
    n_tests++;
    if ({aes_start, cap_arm, tx_start, busy, timeout_err} !== 5'b0 ||
        mem_raddr !== 10'd0 || tx_byte !== 8'd0 || delay_cfg !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_rst_outs: got %b raddr=%0d tx=%0h dly=%0d want 0",
               {aes_start, cap_arm, tx_start, busy, timeout_err},
               mem_raddr, tx_byte, delay_cfg);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    pend = 0; hold2 = 0;
    frame_q.delete();
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (frame_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_quiet: got %0d bytes busy=%b want 0 0",
               frame_q.size(), busy);
    end
    run_frame(8'h01, 8, -1, 0);
    e = frame_err();
    n_tests++;
    if (e !== -1 || r_delay0 !== 5'd1) begin
      n_fail++;
      $display("FAIL mid_fresh: bad byte %0d delay=%0d want none 1",
               e, r_delay0);
    end
    n_tests++;
    if (dbl_start !== 0) begin
      n_fail++; $display("FAIL tx_double_start: got %0d want 0", dbl_start);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_ignore();
    test_wrap_terminal();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_trace_sequencer.md
AES_TRACE_SEQUENCER -- requirements
Module: aes_trace_sequencer

Interface
REQ-001 SHALL have parameter NSAMP, default 512: number of sensor samples per frame; 48+NSAMP SHALL be <= 1024.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum cycles from aes_start to aes_done.
REQ-003 SHALL have parameter COOLDOWN, default 4096: idle cycles after each frame, for PDN recovery.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_vld  input  1  one-cycle strobe: cmd_byte valid (from UART RX).
REQ-007 cmd_byte  input  8  host command byte.
REQ-008 aes_done  input  1  AES ciphertext valid (level or pulse).
REQ-009 mem_rdata  input  8  frame-source byte; valid one cycle after mem_raddr is driven.
REQ-010 tx_done  input  1  one-cycle strobe: UART TX finished the current byte.
REQ-011 aes_start  output  1  one-cycle pulse that launches an encryption.
REQ-012 cap_arm  output  1  high while the sensor capture window is open.
REQ-013 mem_raddr  output  10  frame read address: 0-15 PT, 16-31 key, 32-47 CT, 48.. samples.
REQ-014 tx_start  output  1  one-cycle pulse: tx_byte valid to UART TX.
REQ-015 tx_byte  output  8  byte to transmit.
REQ-016 busy  output  1  low only in IDLE.
REQ-017 delay_cfg  output  5  delay-line setting for the sensor/clock tap.
REQ-018 timeout_err  output  1  sticky flag: last run hit TIMEOUT.

Function
REQ-019 States SHALL be: IDLE, START, WAIT_DONE, SYNC, RD, LOAD, WAIT_TX, COOL.
REQ-020 IDLE: on cmd_vld with cmd_byte=0xFA, delay_cfg SHALL increment mod 32 (31->0), then the FSM SHALL go to START.
REQ-021 IDLE: on cmd_vld with cmd_byte 0x00-0x1F, delay_cfg SHALL load cmd_byte[4:0], then the FSM SHALL go to START.
REQ-022 IDLE: any other cmd_byte SHALL be ignored; cmd_vld outside IDLE SHALL be ignored.
REQ-023 Any accepted command SHALL clear timeout_err.
REQ-024 START: aes_start=1 for exactly one cycle; cap_arm SHALL rise in the same cycle; cycle counter cleared; next state WAIT_DONE.
REQ-025 WAIT_DONE: the counter SHALL increment each cycle; aes_done=1 SHALL go to SYNC.
REQ-026 WAIT_DONE: counter=TIMEOUT-1 without aes_done SHALL set timeout_err and go to COOL with no frame sent.
REQ-027 If aes_done and the terminal count coincide, aes_done SHALL win.
REQ-028 cap_arm SHALL fall on the cycle the FSM leaves WAIT_DONE.
REQ-029 SYNC: tx_byte=0xA5 and tx_start=1 for one cycle; index cleared to 0; next state WAIT_TX.
REQ-030 RD: mem_raddr=index; next state LOAD.
REQ-031 LOAD: tx_byte<=mem_rdata, tx_start=1 for one cycle; next state WAIT_TX.
REQ-032 WAIT_TX: stay until tx_done.
- If the byte just sent was the last (index=47+NSAMP), go to COOL.
- Otherwise index increments (0xA5 sync does not advance index) and go to RD.
REQ-033 tx_done outside WAIT_TX SHALL be ignored.
REQ-034 Frame length SHALL be exactly 49+NSAMP bytes; tx_start SHALL never pulse twice without an intervening tx_done.
REQ-035 COOL: count COOLDOWN cycles, then go to IDLE.
REQ-036 busy SHALL equal (state != IDLE), registered.

Reset
REQ-037 rst SHALL force IDLE and clear counters, index, aes_start, tx_start, cap_arm, mem_raddr, tx_byte, timeout_err and delay_cfg to 0, from any state including mid-frame.
REQ-038 After rst no tx_start SHALL occur until a new accepted command.

Verification
REQ-039 Reset, cmd 0x07, aes_done 20 cycles after aes_start -> delay_cfg=7; one aes_start pulse; cap_arm high 20 cycles; 561 bytes sent: 0xA5, then mem[0..559] in order.
REQ-040 delay_cfg=31, cmd 0xFA -> delay_cfg=0 and run starts; cmd 0x40 in IDLE -> ignored, busy stays 0.
REQ-041 aes_done never asserted -> timeout_err=1 at cycle TIMEOUT after aes_start; no tx_start; busy low after COOLDOWN; next accepted cmd clears timeout_err.
REQ-042 aes_done on the terminal-count cycle -> timeout_err=0 and frame sent.
REQ-043 Commands and spurious tx_done pulses injected during WAIT_TX and COOL -> no effect on frame content or length.
REQ-044 rst asserted mid-sample stream -> next cycle all outputs 0, state IDLE; a fresh command yields a complete frame.
